// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch vs. data) in front of a single-port memory.
// Data has priority, but a pending fetch is served after STARVE_LIMIT consecutive data grants.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall_if,
    output logic        stall_mem
);

    // The starvation counter is two bits wide, so the limit must fit in it.
    localparam logic [1:0] LIMIT = 2'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t     state, state_nx;
    logic [1:0] starve_cnt, starve_nx;
    logic       grant_i, grant_d;

    always_comb begin
        state_nx  = state;
        starve_nx = starve_cnt;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && (!if_req || starve_cnt < LIMIT)) begin
                    grant_d  = 1'b1;
                    state_nx = BUSY_D;
                    if (!if_req)
                        starve_nx = 2'd0;
                    else if (starve_cnt != LIMIT)
                        starve_nx = starve_cnt + 2'd1;
                end else if (if_req) begin
                    grant_i   = 1'b1;
                    state_nx  = BUSY_I;
                    starve_nx = 2'd0;
                end
            end
            BUSY_I:  if (mem_ack) state_nx = IDLE;
            BUSY_D:  if (mem_ack) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= 2'd0;
        end else begin
            state      <= state_nx;
            starve_cnt <= starve_nx;
        end
    end

    // Memory-side request registers: captured once at grant, held for the whole access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
        end else begin
            mem_req <= (state_nx != IDLE);
            if (grant_d) begin
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
            end else if (grant_i) begin
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= 32'd0;
            end
        end
    end

    // Completion: one-cycle valid pulses; read data holds between completions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            if_rdata <= 32'd0;
            d_rdata  <= 32'd0;
        end else begin
            if_valid <= (state == BUSY_I) && mem_ack;
            d_valid  <= (state == BUSY_D) && mem_ack;
            if ((state == BUSY_I) && mem_ack)
                if_rdata <= mem_rdata;
            if ((state == BUSY_D) && mem_ack && !mem_we)
                d_rdata <= mem_rdata;
        end
    end

    assign stall_if  = if_req & ~if_valid;
    assign stall_mem = d_req & ~d_valid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of the arbitration and completion rules.
module tb_mem_arbiter;

    localparam int LIMIT = 3;
    localparam logic [31:0] A_I = 32'h100;
    localparam logic [31:0] A_D = 32'h200;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = 32'd0;
    logic [31:0] d_wdata = 32'd0;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ack = 1'b0;
    logic        stall_if;
    logic        stall_mem;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model: who owns the memory (0 none, 1 fetch, 2 data) and registered outputs.
    int          m_owner = 0;
    int          m_starve = 0;
    logic [31:0] m_addr = 0, m_wdata = 0, m_if_rdata = 0, m_d_rdata = 0;
    logic        m_we = 0, m_if_valid = 0, m_d_valid = 0;

    // Memory responder and requester behaviour knobs.
    logic [31:0] mem [logic [31:0]];
    int          fixed_wait = 0;
    int          wait_left = 0;
    logic        mreq_prev = 1'b0;
    bit          auto_req = 0;
    bit          spurious = 0;
    int          glog[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (a ^ 32'hA5A5_0000);
    endfunction

    task automatic model_reset();
        m_owner = 0; m_starve = 0;
        m_addr = 0; m_wdata = 0; m_we = 0;
        m_if_rdata = 0; m_d_rdata = 0;
        m_if_valid = 0; m_d_valid = 0;
    endtask

    task automatic model_edge();
        m_if_valid = 0;
        m_d_valid  = 0;
        if (reset) begin
            model_reset();
        end else if (m_owner == 0) begin
            if (d_req && (!if_req || m_starve < LIMIT)) begin
                m_owner = 2; m_addr = d_addr; m_we = d_we; m_wdata = d_wdata;
                m_starve = if_req ? ((m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1) : 0;
            end else if (if_req) begin
                m_owner = 1; m_addr = if_addr; m_we = 0; m_wdata = 0;
                m_starve = 0;
            end
        end else if (mem_ack) begin
            if (m_owner == 1) begin
                m_if_rdata = mem_rdata;
                m_if_valid = 1;
            end else begin
                if (!m_we) m_d_rdata = mem_rdata;
                m_d_valid = 1;
            end
            m_owner = 0;
        end
    endtask

    task automatic check_all();
        chk("mem_req", 32'(mem_req), 32'(m_owner != 0));
        chk("if_valid", 32'(if_valid), 32'(m_if_valid));
        chk("d_valid", 32'(d_valid), 32'(m_d_valid));
        chk("if_rdata", if_rdata, m_if_rdata);
        chk("d_rdata", d_rdata, m_d_rdata);
        chk("stall_if", 32'(stall_if), 32'(if_req & ~m_if_valid));
        chk("stall_mem", 32'(stall_mem), 32'(d_req & ~m_d_valid));
        if (m_owner != 0 || reset) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_we", 32'(mem_we), 32'(m_we));
            chk("mem_wdata", mem_wdata, m_wdata);
        end
    endtask

    // One clock: model the edge, compare just after it, then drive the next cycle's inputs.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        if (mem_req && !mreq_prev) begin
            glog.push_back((mem_addr == A_I) ? 1 : 2);
            wait_left = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
        end
        mreq_prev = mem_req;
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        if (mem_req) begin
            if (wait_left == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = rd(mem_addr);
                if (mem_we) mem[mem_addr] = mem_wdata;
            end else begin
                wait_left--;
            end
        end else if (spurious && $urandom_range(0, 7) == 0) begin
            mem_ack = 1'b1;
        end
        if (auto_req) begin
            if (!if_req || m_if_valid) begin
                if_req  = ($urandom_range(0, 2) != 0);
                if_addr = {$urandom_range(0, 255), 2'b00};
            end
            if (!d_req || m_d_valid) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = 32'({$urandom_range(0, 15), 2'b00});
                d_wdata = $urandom;
            end
        end
    endtask

    // Run until the chosen valid output pulses; returns ticks taken, -1 on timeout.
    task automatic wait_valid(input bit fetch, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(fetch ? if_valid : d_valid) && n < 30);
        if (!(fetch ? if_valid : d_valid)) n = -1;
    endtask

    initial begin
        int n;
        int cnt;
        bit stall_ok;
        logic [31:0] prev_d;
        int exp_order [8] = '{2, 2, 2, 1, 2, 2, 2, 1};

        // Reset state
        tick();
        tick();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        reset = 1'b0;
        tick();

        // Lone fetch, ack one cycle after mem_req
        fixed_wait = 1;
        mem[32'h10] = 32'h0050_0093;
        if_req = 1'b1; if_addr = 32'h10;
        tick();
        chk("fetch_addr", mem_addr, 32'h10);
        chk("fetch_we", 32'(mem_we), 32'd0);
        wait_valid(1'b1, n);
        chk("fetch_lat", 32'(n + 1), 32'd3);
        chk("fetch_rdata", if_rdata, 32'h0050_0093);
        chk("fetch_stall", 32'(stall_if), 32'd0);
        if_req = 1'b0;
        tick();

        // Load to give d_rdata a value, then a store that must leave it alone
        mem[32'h30] = 32'h1234_5678;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30;
        wait_valid(1'b0, n);
        chk("load_rdata", d_rdata, 32'h1234_5678);
        prev_d = d_rdata;
        d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF;
        tick();
        chk("store_we", 32'(mem_we), 32'd1);
        chk("store_addr", mem_addr, 32'h20);
        chk("store_data", mem_wdata, 32'hDEAD_BEEF);
        wait_valid(1'b0, n);
        chk("store_valid", 32'(n > 0), 32'd1);
        chk("store_keep", d_rdata, prev_d);
        chk("store_mem", rd(32'h20), 32'hDEAD_BEEF);
        d_req = 1'b0; d_we = 1'b0;
        tick();

        // Contention with immediate ack: D,D,D,I repeating
        fixed_wait = 0;
        glog.delete();
        if_req = 1'b1; if_addr = A_I;
        d_req = 1'b1; d_addr = A_D;
        repeat (17) tick();
        chk("order_len", 32'(glog.size() >= 8), 32'd1);
        for (int i = 0; i < 8 && i < glog.size(); i++)
            chk($sformatf("order_%0d", i), 32'(glog[i]), 32'(exp_order[i]));
        if_req = 1'b0; d_req = 1'b0;
        repeat (3) tick();

        // Wait states: ack five cycles after mem_req
        fixed_wait = 5;
        d_req = 1'b1; d_addr = 32'h40;
        cnt = 0; stall_ok = 1; n = 0;
        do begin
            tick();
            n++;
            if (mem_req && mem_addr == 32'h40) cnt++;
            if (!d_valid && !stall_mem) stall_ok = 0;
        end while (!d_valid && n < 30);
        chk("ws_valid", 32'(d_valid), 32'd1);
        chk("ws_req_cycles", 32'(cnt), 32'd6);
        chk("ws_stall", 32'(stall_ok), 32'd1);
        chk("ws_stall_drop", 32'(stall_mem), 32'd0);
        d_req = 1'b0;
        tick();

        // Reset while in BUSY_D, then a stray ack
        fixed_wait = 3;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h50; d_wdata = 32'h5555_AAAA;
        tick();
        chk("abort_busy", 32'(mem_req), 32'd1);
        reset = 1'b1;
        #1;
        model_reset();
        chk("abort_mreq", 32'(mem_req), 32'd0);
        check_all();
        tick();
        d_req = 1'b0; d_we = 1'b0;
        reset = 1'b0;
        tick();
        mem_ack = 1'b1;
        tick();
        chk("abort_no_valid", 32'(d_valid), 32'd0);
        chk("abort_idle", 32'(mem_req), 32'd0);
        mem_ack = 1'b0;
        tick();

        // Randomized traffic with random wait states and stray acks in IDLE
        fixed_wait = -1;
        spurious = 1;
        auto_req = 1;
        repeat (800) tick();
        auto_req = 0;
        spurious = 0;
        if_req = 1'b0; d_req = 1'b0;
        repeat (8) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3: maximum consecutive data grants while a fetch is pending.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port if_req  input  1  fetch request; held high until if_valid.
REQ-005 SHALL have port if_addr  input  32  fetch address; stable while if_req is high.
REQ-006 SHALL have port if_rdata  output  32  fetched instruction.
REQ-007 SHALL have port if_valid  output  1  one-cycle pulse when if_rdata is valid.
REQ-008 SHALL have port d_req  input  1  data request (MemRead or MemWrite of the MEM stage); held high until d_valid.
REQ-009 SHALL have port d_we  input  1  1 = store, 0 = load; stable while d_req is high.
REQ-010 SHALL have port d_addr  input  32  data address.
REQ-011 SHALL have port d_wdata  input  32  store data.
REQ-012 SHALL have port d_rdata  output  32  load data.
REQ-013 SHALL have port d_valid  output  1  one-cycle pulse on data completion (load or store).
REQ-014 SHALL have port mem_req, mem_we  output  1 each  request and write strobe to the single-port memory.
REQ-015 SHALL have port mem_addr, mem_wdata  output  32 each  memory address and write data.
REQ-016 SHALL have port mem_rdata  input  32  memory read data, valid with mem_ack.
REQ-017 SHALL have port mem_ack  input  1  memory completion, one cycle, only while mem_req is high.
REQ-018 SHALL have port stall_if, stall_mem  output  1 each  pipeline stall requests.

Function
REQ-019 SHALL implement FSM states IDLE, BUSY_I, BUSY_D.
REQ-020 IDLE arbitration SHALL work as follows:
- Data is granted if d_req=1 and (if_req=0 or starve_cnt<STARVE_LIMIT).
- Otherwise fetch is granted if if_req=1.
- Otherwise the FSM stays in IDLE.
REQ-021 On grant, the block SHALL move to BUSY_I/BUSY_D on the next edge and register mem_addr, mem_we, mem_wdata from the granted requester; mem_we SHALL be 0 for fetches.
REQ-022 mem_req SHALL be 1 exactly while in BUSY_I or BUSY_D; mem_addr, mem_we and mem_wdata SHALL remain stable throughout.
REQ-023 On mem_ack in BUSY_I, on the next edge the block SHALL:
- load if_rdata with mem_rdata;
- pulse if_valid;
- return to IDLE.
REQ-024 On mem_ack in BUSY_D, on the next edge the block SHALL:
- pulse d_valid;
- load d_rdata with mem_rdata only if mem_we=0;
- return to IDLE.
REQ-025 Every transaction SHALL pass through IDLE; there are no back-to-back grants. Minimum latency from request to valid is 3 cycles (grant edge, ack in the same cycle as mem_req, valid edge).
REQ-026 starve_cnt SHALL be 2 bits wide and behave as follows:
- increments, saturating at STARVE_LIMIT, on each data grant made while if_req=1;
- clears on each fetch grant;
- clears on a data grant made while if_req=0.
REQ-027 stall_if SHALL be the combinational value if_req & ~if_valid; stall_mem SHALL be the combinational value d_req & ~d_valid.
REQ-028 if_rdata and d_rdata SHALL hold their last value between completions.
REQ-029 Requests SHALL be sampled only in IDLE; a request dropped while another requester is served is simply not granted.
REQ-030 mem_ack while in IDLE SHALL be ignored.

Reset
REQ-031 While reset=1 the block SHALL force, immediately:
- state=IDLE, starve_cnt=0;
- mem_req=0, mem_we=0;
- mem_addr, mem_wdata, if_rdata, d_rdata = 0;
- if_valid=0, d_valid=0.
REQ-032 Reset asserted mid-transaction SHALL abort it with no valid pulse; an ack arriving after reset is ignored.

Verification
REQ-033 Lone fetch: if_req=1, if_addr=0x10, ack one cycle after mem_req, mem_rdata=0x00500093 -> mem_addr=0x10, mem_we=0; if_valid pulses with if_rdata=0x00500093; stall_if falls the same cycle.
REQ-034 Store: d_req=1, d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF -> mem_we=1 with that addr/data; d_valid pulses; d_rdata unchanged.
REQ-035 Contention: if_req and d_req both held, ack immediate, STARVE_LIMIT=3 -> grant order D,D,D,I,D,D,D,I; starve_cnt resets after each I.
REQ-036 Wait states: ack delayed 5 cycles -> mem_req and mem_addr stay stable for 6 cycles; stall_mem stays high until the d_valid cycle.
REQ-037 Reset in BUSY_D before ack, then ack pulsed -> mem_req=0 immediately, no d_valid, state IDLE.
